// File: rtl/decoder_strobe_ctrl.sv
// ---------------------------------------------------------------------------
// decoder_strobe_ctrl
//
// Upstream sequencer for a 2-to-4 address decoder. It accepts a line number
// over a valid/ready handshake, drives address1/address0 for one SETUP cycle
// with enable low, raises enable for STROBE_CYCLES cycles, and then keeps
// enable low with the address held for GAP_CYCLES cycles. That hold covers
// the decoder's settling time. Strobes never overlap, and at least one low
// cycle always separates two strobes.
//
// Optional feature (compile-time macro DECODER_SCAN_EN):
//   When defined, a scan_start pulse in IDLE strobes lines 0..3 in order and
//   pulses done once at the end of line 3. When undefined, scan_start is
//   ignored and scan_busy is tied low.
//
// Parameters
//   STROBE_CYCLES  cycles enable is high per strobe (>= 1)
//   GAP_CYCLES     cycles enable is low after a strobe, address held (>= 0)
//   CNT_W          cycle counter width; 2**CNT_W > max(STROBE, GAP)
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous reset, active low
//   req_valid   request present
//   req_ready   controller accepts a request this cycle (IDLE only)
//   req_addr    requested line; bit0 -> address0, bit1 -> address1
//   scan_start  one-cycle pulse that starts an auto-scan (scan builds only)
//   scan_busy   auto-scan in progress
//   address0    decoder address bit 0
//   address1    decoder address bit 1
//   enable      decoder enable
//   done        one-cycle pulse in the final cycle of a request or a scan
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module decoder_strobe_ctrl #(
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic       scan_start,
  output logic       scan_busy,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Counter reload values. When GAP_CYCLES is 0 the GAP state is never
  // entered, so its reload value is clamped to 0 to keep the constant legal.
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic             HAS_GAP     = (GAP_CYCLES > 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       addr_q, addr_n;
  logic             scan_q, scan_n;
  logic             last_line;    // current sequence is the final one
  logic             last_line_n;  // same, evaluated on the next-state values
  logic             seq_end;      // last cycle of the STROBE/GAP tail
  logic             done_n;

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];

`ifdef DECODER_SCAN_EN
  // During a scan, addr_q doubles as the line counter.
  assign last_line   = !scan_q || (addr_q == 2'd3);
  assign last_line_n = !scan_n || (addr_n == 2'd3);
  assign scan_busy   = scan_q;
`else
  // No scan logic. The input is kept referenced only to make its
  // deliberate non-use explicit.
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign last_line   = 1'b1;
  assign last_line_n = 1'b1;
  assign scan_busy   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    scan_n  = scan_q;
    seq_end = 1'b0;

    case (state)
      IDLE: begin
        // A request has priority over a scan start in the same cycle.
        if (req_valid && req_ready) begin
          state_n = SETUP;
          addr_n  = req_addr;
        end
`ifdef DECODER_SCAN_EN
        else if (scan_start && req_ready) begin
          state_n = SETUP;
          addr_n  = 2'd0;
          scan_n  = 1'b1;
        end
`endif
      end

      SETUP: begin
        state_n = STROBE;
        cnt_n   = STROBE_LOAD;
      end

      STROBE: begin
        if (cnt == '0) begin
          if (HAS_GAP) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            seq_end = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      GAP: begin
        if (cnt == '0) seq_end = 1'b1;
        else           cnt_n   = cnt - 1'b1;
      end

      default: state_n = IDLE;
    endcase

    // End of one line's tail. Either return to IDLE or move to the next
    // scan line. The new address is only driven in SETUP, where enable is low.
    if (seq_end) begin
      if (last_line) begin
        state_n = IDLE;
        scan_n  = 1'b0;
      end else begin
        state_n = SETUP;
        addr_n  = addr_q + 2'd1;
      end
    end
  end

  // done is registered and marks the final cycle of the whole sequence: the
  // last GAP cycle, or the last STROBE cycle when there is no GAP.
  always_comb begin
    done_n = 1'b0;
    if (last_line_n && (cnt_n == '0)) begin
      if (HAS_GAP) done_n = (state_n == GAP);
      else         done_n = (state_n == STROBE);
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous. It is checked inside the clocked block
    // and is not in the sensitivity list.
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= 2'd0;
      scan_q    <= 1'b0;
      enable    <= 1'b0;
      req_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr_q    <= addr_n;
      scan_q    <= scan_n;
      enable    <= (state_n == STROBE);
      req_ready <= (state_n == IDLE);
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_decoder_strobe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decoder_strobe_ctrl
//
// Directed bench for decoder_strobe_ctrl at its default parameters
// (STROBE_CYCLES=4, GAP_CYCLES=1).
//
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge. In the table, each row holds the inputs seen at one rising
// edge and the outputs expected just after that edge. The packed expected
// value is {req_ready, enable, address1, address0, done, scan_busy}.
// ---------------------------------------------------------------------------
module tb_decoder_strobe_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_addr = 2'b00;
  logic       scan_start = 1'b0;
  logic       req_ready, scan_busy, address0, address1, enable, done;

  decoder_strobe_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .address0   (address0),
    .address1   (address1),
    .enable     (enable),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [1:0] addr;
    logic       scan;
    logic [5:0] exp;   // {ready, enable, a1, a0, done, busy}
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Hard backstop so that the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic [1:0] a,
                              input logic s, input logic [5:0] e, input string n);
    vec_t t;
    t.rst_n = r; t.valid = v; t.addr = a; t.scan = s; t.exp = e; t.name = n;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] a, input logic s);
    @(negedge clk);
    reset_n = r; req_valid = v; req_addr = a; scan_start = s;
  endtask

  task automatic step_sample();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {req_ready, enable, address1, address0, done, scan_busy};
  endfunction

  initial begin
    int         en_count;
    bit         got_done;
    logic [1:0] line;
    int         pos;
    logic       en_exp;

    // ---- 1: reset held with req_valid=1, then release ----
    for (int i = 0; i < 3; i++) add(0, 1, 2'b10, 0, 6'b000000, "reset_hold");
    add(1, 1, 2'b10, 0, 6'b100000, "reset_release");

    // ---- 2: single request, line 2 ----
    add(1, 1, 2'b10, 0, 6'b001000, "single_c1_setup");
    for (int i = 2; i <= 5; i++) add(1, 0, 2'b00, 0, 6'b011000, "single_strobe");
    add(1, 0, 2'b00, 0, 6'b001010, "single_c6_gap_done");
    add(1, 0, 2'b00, 0, 6'b101000, "single_c7_ready");

    // ---- 3: back-to-back, valid held: line 1 then line 3 ----
    add(1, 1, 2'b01, 0, 6'b000100, "b2b_a_setup");
    for (int i = 2; i <= 5; i++) add(1, 1, 2'b01, 0, 6'b010100, "b2b_a_strobe");
    add(1, 1, 2'b01, 0, 6'b000110, "b2b_a_gap_done");
    add(1, 1, 2'b11, 0, 6'b100100, "b2b_a_ready");
    add(1, 1, 2'b11, 0, 6'b001100, "b2b_b_setup");
    for (int i = 2; i <= 5; i++) add(1, 0, 2'b00, 0, 6'b011100, "b2b_b_strobe");
    add(1, 0, 2'b00, 0, 6'b001110, "b2b_b_gap_done");
    add(1, 0, 2'b00, 0, 6'b101100, "b2b_b_ready");

    // ---- 4: reset sampled mid-STROBE ----
    add(1, 1, 2'b01, 0, 6'b000100, "midrst_setup");
    add(1, 0, 2'b00, 0, 6'b010100, "midrst_c2");
    add(1, 0, 2'b00, 0, 6'b010100, "midrst_c3");
    add(0, 0, 2'b00, 0, 6'b000000, "midrst_c4_reset");
    add(0, 0, 2'b00, 0, 6'b000000, "midrst_hold");
    for (int i = 0; i < 4; i++) add(1, 0, 2'b00, 0, 6'b100000, "midrst_idle_no_done");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].addr, vecs[i].scan);
      step_sample();
      check($sformatf("%s[%0d]", vecs[i].name, i), 32'(outs()), 32'(vecs[i].exp));
    end

    // ---- request and scan_start together: the request wins ----
    drive(1, 1, 2'b00, 1);
    step_sample();
    check("req_vs_scan_setup", 32'(outs()), 32'(6'b000000));
    drive(1, 0, 2'b00, 0);
    en_count = 0;
    got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      step_sample();
      if (enable) en_count++;
      if (scan_busy) en_count += 100;  // no scan may start
      if (done) got_done = 1;
    end
    check("req_vs_scan_done_seen", 32'(got_done), 32'd1);
    check("req_vs_scan_enable_cycles", en_count, 4);
    step_sample();
    check("req_vs_scan_ready_again", 32'(outs()), 32'(6'b100000));

`ifdef DECODER_SCAN_EN
    // ---- 5: auto-scan of lines 0..3; requests are ignored during the scan ----
    for (int k = 1; k <= 24; k++) begin
      drive(1, (k != 1), 2'b10, (k == 1));
      step_sample();
      line   = 2'((k - 1) / 6);
      pos    = (k - 1) % 6;
      en_exp = (pos >= 1) && (pos <= 4);
      check($sformatf("scan_c%0d", k), 32'(outs()),
            32'({1'b0, en_exp, line[1], line[0], (k == 24), 1'b1}));
    end
    drive(1, 1, 2'b10, 0);
    step_sample();
    check("scan_end_idle", 32'(outs()), 32'(6'b101100));
    drive(1, 0, 2'b00, 0);
    step_sample();
`else
    // ---- 6: without the scan feature, scan_start does nothing ----
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 2'b00, 1);
      step_sample();
      check($sformatf("noscan_c%0d", k), 32'(outs()), 32'(6'b100000));
    end
    drive(1, 0, 2'b00, 0);
    step_sample();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
